// File: rtl/timer_counter_pkg.sv
// Shared timer constants: bus word offsets, CTRL bit positions, mode
// encodings and FSM state encodings. The CPU side imports this file too.
package timer_counter_pkg;

    // Word select taken from bus address bits [3:2]
    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;
    localparam logic [1:0] ADDR_UNUSED = 2'd3;

    // CTRL register layout
    localparam int unsigned CTRL_EN_BIT   = 0;
    localparam int unsigned CTRL_MODE_LSB = 1;
    localparam int unsigned CTRL_MODE_MSB = 2;
    localparam int unsigned CTRL_IM_BIT   = 3;

    // Prescaler counter width (PRESCALE is at most 65535)
    localparam int unsigned PRESCALE_W = 16;

    typedef enum logic [1:0] {
        MODE_ONESHOT = 2'd0,
        MODE_RELOAD  = 2'd1,
        MODE_RSVD2   = 2'd2,
        MODE_RSVD3   = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_t;

endpackage

// File: rtl/tc_prescaler.sv
// Prescaler: divides clk so that tick pulses once every PRESCALE cycles
// while clr is low. clr forces the divider back to zero.
// Ports:
//   clk   - system clock
//   reset - asynchronous active-low reset
//   clr   - synchronous clear; also suppresses tick
//   tick  - one-cycle pulse on the last cycle of each PRESCALE period
module tc_prescaler
    import timer_counter_pkg::*;
#(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam logic [PRESCALE_W-1:0] LAST = PRESCALE_W'(PRESCALE - 1);

    logic [PRESCALE_W-1:0] cnt;

    assign tick = !clr && (cnt == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr || (cnt == LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/timer_counter.sv
// Programmable down-counting timer with bus register file and interrupt.
// Registers: CTRL (En, Mode, IM), PRESET (reload value), COUNT (read-only).
// Ports:
//   clk    - system clock
//   reset  - asynchronous active-low reset
//   addr   - word select (0=CTRL, 1=PRESET, 2=COUNT, 3=unused)
//   we     - bus write strobe
//   byteen - per-byte write enable for wdata
//   wdata  - bus write data
//   rdata  - combinational read of the selected register
//   irq    - interrupt request (pending AND IM)
module timer_counter
    import timer_counter_pkg::*;
#(
    parameter int unsigned PRESCALE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [3:0]  byteen,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    state_t      state, state_nxt;
    logic        en, im, pending;
    mode_t       mode;
    logic [31:0] preset, count;

    logic wr_ctrl, wr_ctrl_b0, wr_preset;
    logic en_bus;
    logic load, fire, stop;
    logic clr, tick;

    assign wr_ctrl    = we && (addr == ADDR_CTRL);
    assign wr_ctrl_b0 = wr_ctrl && byteen[0];
    assign wr_preset  = we && (addr == ADDR_PRESET);

    // The FSM looks at En as it will be after this edge's bus write, so a
    // CTRL write that sets En leaves IDLE on that same edge.
    assign en_bus = wr_ctrl_b0 ? wdata[CTRL_EN_BIT] : en;

    // Divider only runs while counting; clear it everywhere else, including
    // the edge on which CNT is left.
    assign clr = (state != S_CNT) || !en_bus;

    tc_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .reset(reset),
        .clr  (clr),
        .tick (tick)
    );

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        fire      = 1'b0;
        stop      = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (en_bus) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                load      = 1'b1;
                state_nxt = S_CNT;
            end
            S_CNT: begin
                if (!en_bus) begin
                    state_nxt = S_IDLE;
                end else if (tick && (count <= 32'd1)) begin
                    fire      = 1'b1;
                    state_nxt = S_INT;
                end
            end
            S_INT: begin
                if (mode == MODE_RELOAD) begin
                    state_nxt = S_LOAD;
                end else begin
                    stop      = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            en      <= 1'b0;
            mode    <= MODE_ONESHOT;
            im      <= 1'b0;
            preset  <= '0;
            count   <= '0;
            pending <= 1'b0;
        end else begin
            state <= state_nxt;

            // Bus write is applied after the FSM's En clear so it wins.
            if (stop) en <= 1'b0;
            if (wr_ctrl_b0) begin
                en   <= wdata[CTRL_EN_BIT];
                mode <= mode_t'(wdata[CTRL_MODE_MSB:CTRL_MODE_LSB]);
                im   <= wdata[CTRL_IM_BIT];
            end

            for (int unsigned i = 0; i < 4; i++) begin
                if (wr_preset && byteen[i]) preset[8*i +: 8] <= wdata[8*i +: 8];
            end

            if (load) begin
                count <= preset;
            end else if (fire) begin
                count <= '0;
            end else if (tick) begin
                count <= count - 32'd1;
            end

            // Pending is raised on entry to INT; in reload mode it drops on
            // the INT->LOAD edge, otherwise only a CTRL write clears it.
            if (fire) begin
                pending <= 1'b1;
            end else if (wr_ctrl) begin
                pending <= 1'b0;
            end else if ((state == S_INT) && (mode == MODE_RELOAD)) begin
                pending <= 1'b0;
            end
        end
    end

    always_comb begin
        rdata = '0;
        unique case (addr)
            ADDR_CTRL:   rdata = {28'd0, im, mode, en};
            ADDR_PRESET: rdata = preset;
            ADDR_COUNT:  rdata = count;
            default:     rdata = '0;
        endcase
    end

    assign irq = pending && im;

endmodule
